async_fifo_write_arbiter: RTL and testbench

Shares the single write port of the asynchronous FIFO between NUM_REQ producers in the write clock domain. Round-robin arbitration with bounded bursts: a granted requester may push up to MAX_BURST words before the grant rotates. Drives write_en/write_data directly into the FIFO write side and throttles on write_full so the FIFO never overflows. Also keeps a free-running count of accepted words per requester for debug.

---
 rtl/async_fifo_write_arbiter_pkg.sv | 22 ++
 rtl/async_fifo_write_arbiter_rr_arbiter.sv | 34 +++
 rtl/async_fifo_write_arbiter.sv | 124 ++++++++++++
 tb/tb_async_fifo_write_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package async_fifo_write_arbiter_pkg;

    // FIFO word width, tied to the FIFO's global width macro.
    localparam int FIFO_DATA_WIDTH = `DATA_WIDTH;

    // Controller states: waiting for requests, or streaming one requester's burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/async_fifo_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i.
module async_fifo_write_arbiter_rr_arbiter
    import async_fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = safe_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;

    // Rotate requests so ptr_i sits at bit 0, then take the lowest set bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        req_dbl = {req_i, req_i} >> ptr_i;
        req_rot = req_dbl[NUM_REQ-1:0];
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            end
        end
        gnt_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/async_fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of the FIFO write port among NUM_REQ producers.
module async_fifo_write_arbiter
    import async_fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int IDX_W     = safe_clog2(NUM_REQ)
) (
    input  logic                          write_clk,
    input  logic                          write_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          write_full,
    output logic                          write_en,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  word_cnt
);

    localparam int BEAT_W = safe_clog2(MAX_BURST);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]   gnt_oh_q, gnt_oh_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   grant_next;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign word_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

    assign grant_id   = grant_q;
    assign grant_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    async_fifo_write_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // State register: controller state, rotation pointer, current grant and beat count.
    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            gnt_oh_q <= '0;
            beat_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            gnt_oh_q <= gnt_oh_d;
            beat_q   <= beat_d;
        end
    end

    // Next state: arbitrate in IDLE; in BURST leave on last word, full burst or abandon.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        gnt_oh_d = gnt_oh_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = BURST;
                    grant_d  = arb_idx;
                    gnt_oh_d = arb_gnt;
                    beat_d   = '0;
                end
            end
            BURST: begin
                if (!req_valid[grant_q] ||
                    (write_en && (req_last[grant_q] || beat_q == BEAT_W'(MAX_BURST - 1)))) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_next;
                end else if (write_en) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: route the granted requester straight onto the FIFO write port, throttled by full.
    always_comb begin
        busy       = (state_q == BURST);
        write_en   = busy && req_valid[grant_q] && !write_full;
        req_ready  = (busy && !write_full) ? gnt_oh_q : '0;
        write_data = write_en ? req_word[grant_q] : '0;
    end

    // Debug counters: one accepted-word count per requester, wrapping naturally.
    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            // NOTE: this counter array is cleared on reset because its value is architecturally visible; plain data storage would not need it.
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (write_en) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
        end
    end

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
// Scoreboard bench: a transaction-level round-robin model predicts the write stream.
module tb_async_fifo_write_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;
    localparam int CW   = 16;
    localparam int MAXW = 32;

    logic              write_clk = 1'b0;
    logic              write_rst;
    logic [N-1:0]      req_valid, req_last, req_ready;
    logic [N*DW-1:0]   req_data;
    logic              write_full, write_en, busy;
    logic [DW-1:0]     write_data;
    logic [1:0]        grant_id;
    logic [N*CW-1:0]   word_cnt;

    async_fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .write_clk  (write_clk),
        .write_rst  (write_rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .write_full (write_full),
        .write_en   (write_en),
        .write_data (write_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .word_cnt   (word_cnt)
    );

    always #5 write_clk = ~write_clk;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q [$];
    wr_t           mon_e;
    logic [DW-1:0] pdata [N][MAXW];
    logic          plast [N][MAXW];
    int            plen [N];
    int            phead [N];
    logic          pend_pop [N];
    int            exp_cnt [N];
    int            m_ptr;
    int            cyc = 0;
    int            s_cyc;
    int            wc_q [$];
    int            first_id;
    int            full_mode;
    int            full_from;
    int            n_checks;
    int            n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(posedge write_clk) cyc <= cyc + 1;

    // Producer driver: applies accepted pops after the edge and presents each queue head.
    initial begin
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        write_full = 1'b0;
        forever begin
            @(posedge write_clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pend_pop[i] && !write_rst) phead[i]++;
                pend_pop[i] = 1'b0;
                if (phead[i] < plen[i]) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*DW +: DW]  = pdata[i][phead[i]];
                    req_last[i]           = plast[i][phead[i]];
                end else begin
                    req_valid[i]          = 1'b0;
                    req_data[i*DW +: DW]  = '0;
                    req_last[i]           = 1'b0;
                end
            end
            case (full_mode)
                1:       write_full = ($urandom_range(0, 3) == 0);
                2:       write_full = (cyc >= full_from) && (cyc < full_from + 5);
                default: write_full = 1'b0;
            endcase
        end
    end

    // Monitor: compares each FIFO write against the scoreboard and records handshakes.
    always @(negedge write_clk) begin
        if (!write_rst) begin
            if (write_full && busy) check("stall_outputs", {write_en, req_ready}, 0);
            if (write_en) begin
                check("scoreboard_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_id", grant_id, mon_e.id);
                    check("wr_data", write_data, mon_e.data);
                end
                wc_q.push_back(cyc - s_cyc);
                if (wc_q.size() == 1) first_id = grant_id;
            end
            for (int i = 0; i < N; i++) pend_pop[i] = req_valid[i] && req_ready[i];
        end
    end

    // Reference model: round-robin over whole producer queues, bursts cut at MB, last or empty.
    task automatic build_expected();
        int pos [N];
        int sel;
        int k;
        for (int i = 0; i < N; i++) pos[i] = 0;
        while (1) begin
            sel = -1;
            for (int j = 0; j < N; j++) begin
                if (sel < 0 && pos[(m_ptr + j) % N] < plen[(m_ptr + j) % N]) sel = (m_ptr + j) % N;
            end
            if (sel < 0) break;
            k = 0;
            while (pos[sel] < plen[sel] && k < MB) begin
                exp_q.push_back('{sel, pdata[sel][pos[sel]]});
                exp_cnt[sel]++;
                k++;
                pos[sel]++;
                if (plast[sel][pos[sel] - 1]) break;
            end
            m_ptr = (sel + 1) % N;
        end
    endtask

    // last_mode: 0 never, 1 on final word only, 2 random.
    task automatic load4(input int l0, input int l1, input int l2, input int l3,
                         input int last_mode, input int fmode);
        int lens [N];
        lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
        @(negedge write_clk);
        #2;
        for (int i = 0; i < N; i++) begin
            plen[i]     = lens[i];
            phead[i]    = 0;
            pend_pop[i] = 1'b0;
            for (int w = 0; w < MAXW; w++) begin
                pdata[i][w] = DW'($urandom);
                case (last_mode)
                    1:       plast[i][w] = (w == lens[i] - 1);
                    2:       plast[i][w] = ($urandom_range(0, 3) == 0);
                    default: plast[i][w] = 1'b0;
                endcase
            end
        end
        wc_q.delete();
        first_id  = -1;
        s_cyc     = cyc + 1;
        full_from = s_cyc + 3;
        full_mode = fmode;
        build_expected();
    endtask

    function automatic bit all_drained();
        bit d = 1'b1;
        for (int i = 0; i < N; i++) if (phead[i] < plen[i]) d = 1'b0;
        return d;
    endfunction

    task automatic wait_done(input int budget);
        int n = 0;
        while (n < budget && !(exp_q.size() == 0 && all_drained())) begin
            @(posedge write_clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (3) @(posedge write_clk);
        #2;
        full_mode = 0;
    endtask

    task automatic check_counts();
        for (int i = 0; i < N; i++) check("word_cnt", word_cnt[i*CW +: CW], exp_cnt[i] % 65536);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_ptr     = 0;
        full_mode = 0;
        first_id  = -1;
        s_cyc     = 0;
        for (int i = 0; i < N; i++) begin
            exp_cnt[i]  = 0;
            plen[i]     = 0;
            phead[i]    = 0;
            pend_pop[i] = 1'b0;
        end
        write_rst = 1'b1;
        repeat (3) @(posedge write_clk);
        #2;
        check("rst_write_en", write_en, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_write_data", write_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_word_cnt", word_cnt, 0);
        @(posedge write_clk);
        #2 write_rst = 1'b0;

        // Four contending requesters, no last: bursts of MB, one idle cycle between.
        load4(8, 8, 8, 8, 0, 0);
        wait_done(300);
        check("rr_first_grant", first_id, 0);
        check("rr_writes", wc_q.size(), 32);
        if (wc_q.size() == 32) begin
            check("rr_first_latency", wc_q[0], 1);
            check("rr_idle_gap", wc_q[4], 6);
            check("rr_span", wc_q[31], 39);
        end
        check_counts();

        // Single requester, three words ending in last.
        load4(3, 0, 0, 0, 1, 0);
        wait_done(100);
        check("single_writes", wc_q.size(), 3);
        if (wc_q.size() == 3) begin
            check("single_latency", wc_q[0], 1);
            check("single_back_to_back", wc_q[2], 3);
        end
        check("single_busy_drops", busy, 0);
        check_counts();

        // Requester 1 stalled by full for five cycles after its second word.
        load4(0, 6, 0, 0, 0, 2);
        wait_done(100);
        check("full_writes", wc_q.size(), 6);
        if (wc_q.size() == 6) begin
            check("full_second", wc_q[1], 2);
            check("full_resume", wc_q[2], 8);
            check("full_burst_end", wc_q[3], 9);
            check("full_regrant", wc_q[4], 11);
        end
        check_counts();

        // Pointer now at 2: requesters 1 and 3 contend, 3 wins first.
        load4(0, 2, 0, 2, 1, 0);
        wait_done(100);
        check("ptr2_first_grant", first_id, 3);

        // Requester 2 abandons after one word; requester 3 follows before 0.
        load4(2, 0, 1, 2, 0, 0);
        wait_done(100);
        check("abandon_first_grant", first_id, 2);
        if (wc_q.size() == 5) check("abandon_next_write", wc_q[1], 4);
        else check("abandon_writes", wc_q.size(), 5);
        check_counts();

        // Reset pulsed during the third beat of a burst.
        load4(8, 0, 0, 0, 0, 0);
        for (int n = 0; n < 20 && wc_q.size() < 3; n++) begin
            @(negedge write_clk);
            #1;
        end
        check("rst_reached_beat3", wc_q.size(), 3);
        write_rst = 1'b1;
        #1;
        check("midrst_write_en", write_en, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_grant_id", grant_id, 0);
        check("midrst_word_cnt", word_cnt, 0);
        for (int i = 0; i < N; i++) begin
            plen[i]     = 0;
            phead[i]    = 0;
            pend_pop[i] = 1'b0;
            exp_cnt[i]  = 0;
        end
        exp_q.delete();
        m_ptr = 0;
        @(posedge write_clk);
        #2 write_rst = 1'b0;
        load4(2, 0, 2, 0, 0, 0);
        wait_done(100);
        check("postrst_first_grant", first_id, 0);
        check_counts();

        // Randomized traffic with random last flags and random backpressure.
        for (int r = 0; r < 8; r++) begin
            load4($urandom_range(0, 10), $urandom_range(0, 10),
                  $urandom_range(0, 10), $urandom_range(0, 10), 2, 1);
            wait_done(600);
            check_counts();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
